// File: rtl/param_angle_controller.sv
// Multi-axis P controller: maps receiver targets to angles, scales error by K_P through one shared multiplier, clamps per axis.
// Run latency is 3*NUM_AXES+2 cycles from the sampled start edge; start edges during a run queue as a single pending request.
module param_angle_controller #(
    parameter int NUM_AXES   = 4,
    parameter int DATA_W     = 16,
    parameter int REC_W      = 8,
    parameter int MAP_SHIFT  = 2,
    parameter int MAP_OFFSET = 500
) (
    input  logic                         us_clk,
    input  logic                         reset,
    input  logic                         start_signal,
    input  logic [NUM_AXES*REC_W-1:0]    target_bus,
    input  logic [NUM_AXES*DATA_W-1:0]   actual_bus,
    input  logic [NUM_AXES*DATA_W-1:0]   gain_bus,
    input  logic [NUM_AXES*5-1:0]        shift_bus,
    input  logic [NUM_AXES*DATA_W-1:0]   limit_max_bus,
    input  logic [NUM_AXES*DATA_W-1:0]   limit_min_bus,
    input  logic [NUM_AXES-1:0]          mode_bus,
    input  logic [NUM_AXES-1:0]          invert_bus,
    input  logic [1:0]                   boost_sel,
    output logic [NUM_AXES*DATA_W-1:0]   rate_out_bus,
    output logic [NUM_AXES*DATA_W-1:0]   angle_error_bus,
    output logic [NUM_AXES-1:0]          sat_flags,
    output logic                         active_signal,
    output logic                         complete_signal
);
    localparam int EW = DATA_W + 4;
    localparam int PW = 2 * DATA_W;
    localparam int IW = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam logic [IW-1:0] LAST_AXIS = IW'(NUM_AXES - 1);
    localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [EW-1:0] E_MAX = {{5{1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [EW-1:0] E_MIN = {{5{1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [PW-1:0] P_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] P_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LATCH, MAP, SCALE, LIMIT} state_t;
    state_t state, state_n;

    logic [IW-1:0]                axis;
    logic [31:0]                  ax_i;
    logic                         start_prev, pending, start_rise;
    logic [NUM_AXES*REC_W-1:0]    l_target;
    logic [NUM_AXES*DATA_W-1:0]   l_actual, l_gain, l_max, l_min;
    logic [NUM_AXES*5-1:0]        l_shift;
    logic [NUM_AXES-1:0]          l_mode, l_invert;
    logic [1:0]                   l_boost;
    logic signed [DATA_W-1:0]     err_r, scaled_r;

    logic [REC_W-1:0]             cur_target;
    logic signed [DATA_W-1:0]     cur_actual, cur_gain, cur_max, cur_min;
    logic [4:0]                   cur_shift;
    logic signed [EW-1:0]         tgt_ext, mapped, boosted, act_ext, err_w;
    logic signed [DATA_W-1:0]     err_sat, scale_sat, lim_v;
    logic signed [PW-1:0]         prod, shifted;
    logic                         lim_sat;

    assign ax_i          = 32'(axis);
    assign start_rise    = start_signal & ~start_prev;
    // A queued request keeps the block reported busy across the turnaround cycle in IDLE.
    assign active_signal = (state != IDLE) | pending;

    always_comb begin
        cur_target = l_target[ax_i*REC_W +: REC_W];
        cur_actual = l_actual[ax_i*DATA_W +: DATA_W];
        cur_gain   = l_gain[ax_i*DATA_W +: DATA_W];
        cur_max    = l_max[ax_i*DATA_W +: DATA_W];
        cur_min    = l_min[ax_i*DATA_W +: DATA_W];
        cur_shift  = l_shift[ax_i*5 +: 5];

        tgt_ext = {{(EW-REC_W){1'b0}}, cur_target};
        mapped  = (tgt_ext <<< MAP_SHIFT) - EW'(MAP_OFFSET);
        case (l_boost)
            2'd1:    boosted = mapped <<< 1;
            2'd2:    boosted = mapped <<< 2;
            default: boosted = mapped;
        endcase
        act_ext = EW'(cur_actual);
        if (l_mode[axis])        err_w = boosted;
        else if (l_invert[axis]) err_w = boosted + act_ext;
        else                     err_w = boosted - act_ext;
        if (err_w > E_MAX)       err_sat = D_MAX;
        else if (err_w < E_MIN)  err_sat = D_MIN;
        else                     err_sat = err_w[DATA_W-1:0];

        prod    = PW'(err_r) * PW'(cur_gain);
        shifted = prod >>> cur_shift;
        if (shifted > P_MAX)      scale_sat = D_MAX;
        else if (shifted < P_MIN) scale_sat = D_MIN;
        else                      scale_sat = shifted[DATA_W-1:0];

        lim_v   = scaled_r;
        lim_sat = 1'b0;
        if (cur_min > cur_max) begin
            lim_v   = cur_min;
            lim_sat = 1'b1;
        end else if (scaled_r > cur_max) begin
            lim_v   = cur_max;
            lim_sat = 1'b1;
        end else if (scaled_r < cur_min) begin
            lim_v   = cur_min;
            lim_sat = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pending) state_n = LATCH;
            LATCH:   state_n = MAP;
            MAP:     state_n = SCALE;
            SCALE:   state_n = LIMIT;
            LIMIT:   state_n = (axis == LAST_AXIS) ? IDLE : MAP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            axis            <= '0;
            start_prev      <= 1'b0;
            pending         <= 1'b0;
            l_target        <= '0;
            l_actual        <= '0;
            l_gain          <= '0;
            l_max           <= '0;
            l_min           <= '0;
            l_shift         <= '0;
            l_mode          <= '0;
            l_invert        <= '0;
            l_boost         <= '0;
            err_r           <= '0;
            scaled_r        <= '0;
            rate_out_bus    <= '0;
            angle_error_bus <= '0;
            sat_flags       <= '0;
            complete_signal <= 1'b0;
        end else begin
            state           <= state_n;
            start_prev      <= start_signal;
            complete_signal <= (state == LIMIT) && (axis == LAST_AXIS);
            // Single-entry request queue: extra edges while a request waits are dropped.
            if (state == IDLE && pending) pending <= start_rise;
            else if (start_rise)          pending <= 1'b1;
            case (state)
                LATCH: begin
                    axis     <= '0;
                    l_target <= target_bus;
                    l_actual <= actual_bus;
                    l_gain   <= gain_bus;
                    l_max    <= limit_max_bus;
                    l_min    <= limit_min_bus;
                    l_shift  <= shift_bus;
                    l_mode   <= mode_bus;
                    l_invert <= invert_bus;
                    l_boost  <= boost_sel;
                end
                MAP:   err_r    <= err_sat;
                SCALE: scaled_r <= scale_sat;
                LIMIT: begin
                    rate_out_bus[ax_i*DATA_W +: DATA_W]    <= lim_v;
                    angle_error_bus[ax_i*DATA_W +: DATA_W] <= err_r;
                    sat_flags[axis]                        <= lim_sat;
                    if (axis != LAST_AXIS) axis <= axis + IW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
